// File: rtl/regbank_pkg.sv
// Shared types for the register-bank writeback path: address/data widths and the queued entry.
package regbank_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue: up to two pushes (slot a older than slot b) and one pop per edge,
// synchronous flush, exposes its storage and read pointer so the top can search pending results.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push_a,
    input  wb_entry_t                    i_entry_a,
    input  logic                         i_push_b,
    input  wb_entry_t                    i_entry_b,
    input  logic                         i_pop,
    output wb_entry_t                    o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic [$clog2(DEPTH)-1:0]     o_rptr,
    output wb_entry_t [DEPTH-1:0]        o_entries
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         w_wptr_b;
    logic                  w_pop;

    // Slot b lands right behind slot a; the top only raises push_b together with push_a.
    assign w_wptr_b = r_wptr + PW'(i_push_a);
    assign w_pop    = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(i_push_a) + PW'(i_push_b);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (i_push_a) r_mem[r_wptr]   <= i_entry_a;
            if (i_push_b) r_mem[w_wptr_b] <= i_entry_b;
        end
    end

    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_rptr    = r_rptr;
    assign o_entries = r_mem;

endmodule

// File: rtl/regbank_writeback_unit.sv
// Write side of the 16x32 register bank: orders load/ALU results into a queue and issues one
// registered write per cycle. Define WB_BYPASS_EN to enable combinational bypass of pending results.
module regbank_writeback_unit
    import regbank_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     we,
    output logic [ADDR_W-1:0]        dest,
    output logic [DATA_W-1:0]        Din,
    output logic [$clog2(DEPTH):0]   pending,
    input  logic [ADDR_W-1:0]        srcadd1,
    input  logic [ADDR_W-1:0]        srcadd2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DATA_W-1:0]        byp1,
    output logic [DATA_W-1:0]        byp2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a source transfers on a clk edge where its valid and ready are both high and
    // flush is low; ready never depends on the same-cycle pop.
    logic                  w_mem_take;
    logic                  w_mem_acc;
    logic                  w_alu_acc;
    logic                  w_push_a;
    logic                  w_push_b;
    wb_entry_t             w_mem_entry;
    wb_entry_t             w_alu_entry;
    wb_entry_t             w_entry_a;
    wb_entry_t             w_head;
    logic [CW-1:0]         w_count;
    logic [PW-1:0]         w_rptr;
    wb_entry_t [DEPTH-1:0] w_entries;

    assign mem_ready  = (w_count < CW'(DEPTH));
    assign w_mem_take = mem_valid & mem_ready;
    assign alu_ready  = ((w_count + CW'(w_mem_take)) < CW'(DEPTH));

    assign w_mem_acc  = w_mem_take & ~flush;
    assign w_alu_acc  = alu_valid & alu_ready & ~flush;

    assign w_mem_entry = '{dest: mem_dest, data: mem_data};
    assign w_alu_entry = '{dest: alu_dest, data: alu_data};

    // The load result is always the older of two same-edge pushes.
    assign w_push_a  = w_mem_acc | w_alu_acc;
    assign w_entry_a = w_mem_acc ? w_mem_entry : w_alu_entry;
    assign w_push_b  = w_mem_acc & w_alu_acc;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_push_a  (w_push_a),
        .i_entry_a (w_entry_a),
        .i_push_b  (w_push_b),
        .i_entry_b (w_alu_entry),
        .i_pop     (1'b1),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_rptr    (w_rptr),
        .o_entries (w_entries)
    );

    assign pending = w_count;

    // On flush the in-flight write has already been presented; only the next one is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            we   <= 1'b0;
            dest <= '0;
            Din  <= '0;
        end else if (flush) begin
            we   <= 1'b0;
        end else if (w_count != '0) begin
            we   <= 1'b1;
            dest <= w_head.dest;
            Din  <= w_head.data;
        end else begin
            we   <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Output register has lowest priority; walking head->tail lets the youngest match win.
    always_comb begin
        hit1 = 1'b0;
        byp1 = '0;
        hit2 = 1'b0;
        byp2 = '0;
        if (we && (dest == srcadd1)) begin
            hit1 = 1'b1;
            byp1 = Din;
        end
        if (we && (dest == srcadd2)) begin
            hit2 = 1'b1;
            byp2 = Din;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < w_count) begin
                if (w_entries[w_rptr + PW'(i)].dest == srcadd1) begin
                    hit1 = 1'b1;
                    byp1 = w_entries[w_rptr + PW'(i)].data;
                end
                if (w_entries[w_rptr + PW'(i)].dest == srcadd2) begin
                    hit2 = 1'b1;
                    byp2 = w_entries[w_rptr + PW'(i)].data;
                end
            end
        end
    end
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{w_entries, w_rptr, srcadd1, srcadd2};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign byp1 = '0;
    assign byp2 = '0;
`endif

endmodule
